// File: rtl/johnson_decoder.sv
// Johnson code decoder with registered phase, error pulses and a saturating error counter.
// Define JOHNSON_DECODER_SEQ_CHECK_EN to build the sequence tracker (locked, skip_err).
module johnson_decoder #(
  parameter int unsigned SIZE = 7,
  parameter int unsigned PW   = 4
) (
  input  logic          clk,
  input  logic          r,
  input  logic [0:SIZE] jc,
  input  logic          en,
  input  logic          clr_cnt,
  output logic [PW-1:0] phase,
  output logic          valid,
  output logic          illegal,
  output logic          skip_err,
  output logic          locked,
  output logic [7:0]    err_cnt
);

  localparam int unsigned NumStates = 2 * (SIZE + 1);

  // Code word for phase p: a growing run of ones from bit 0, then a growing run of zeros.
  function automatic logic [0:SIZE] johnson_word(int unsigned p);
    logic [0:SIZE] w;
    for (int unsigned i = 0; i <= SIZE; i++) begin
      if (p <= SIZE + 1) w[i] = (i < p);
      else               w[i] = (i + SIZE + 2 > p);
    end
    return w;
  endfunction

  logic          dec_legal;
  logic [PW-1:0] dec_phase;

  always_comb begin
    dec_legal = 1'b0;
    dec_phase = '0;
    for (int unsigned p = 0; p < NumStates; p++) begin
      if (jc == johnson_word(p)) begin
        dec_legal = 1'b1;
        dec_phase = PW'(p);
      end
    end
  end

  logic          valid_d;
  logic          illegal_d;
  logic          err_event;
  logic [PW-1:0] phase_d;
  logic [7:0]    err_cnt_d;

`ifdef JOHNSON_DECODER_SEQ_CHECK_EN
  typedef enum logic [0:0] {StUnlocked, StLocked} track_e;

  localparam logic [PW-1:0] LastPhase = PW'(NumStates - 1);

  track_e        state_q, state_d;
  logic          has_prev_q, has_prev_d;
  logic          skip_d;
  logic          is_succ;
  logic [PW-1:0] succ_phase;

  // phase always holds the last legal sample, so it doubles as the previous phase.
  assign succ_phase = (phase == LastPhase) ? '0 : phase + 1'b1;
  assign is_succ    = has_prev_q && (dec_phase == succ_phase);
  assign err_event  = illegal_d | skip_d;
`else
  assign err_event  = illegal_d;
`endif

  always_comb begin
    valid_d    = 1'b0;
    illegal_d  = 1'b0;
    phase_d    = phase;
`ifdef JOHNSON_DECODER_SEQ_CHECK_EN
    state_d    = state_q;
    has_prev_d = has_prev_q;
    skip_d     = 1'b0;
`endif
    if (en) begin
      if (dec_legal) begin
        valid_d = 1'b1;
        phase_d = dec_phase;
`ifdef JOHNSON_DECODER_SEQ_CHECK_EN
        has_prev_d = 1'b1;
        if (is_succ) begin
          state_d = StLocked;
        end else begin
          state_d = StUnlocked;
          skip_d  = (state_q == StLocked);
        end
`endif
      end else begin
        illegal_d = 1'b1;
`ifdef JOHNSON_DECODER_SEQ_CHECK_EN
        state_d    = StUnlocked;
        has_prev_d = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (err_event && (err_cnt != 8'hFF)) begin
      err_cnt_d = err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      phase   <= '0;
      valid   <= 1'b0;
      illegal <= 1'b0;
      err_cnt <= '0;
    end else begin
      phase   <= phase_d;
      valid   <= valid_d;
      illegal <= illegal_d;
      err_cnt <= err_cnt_d;
    end
  end

`ifdef JOHNSON_DECODER_SEQ_CHECK_EN
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q    <= StUnlocked;
      has_prev_q <= 1'b0;
      skip_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      has_prev_q <= has_prev_d;
      skip_err   <= skip_d;
    end
  end

  assign locked = (state_q == StLocked);
`else
  assign locked   = 1'b0;
  assign skip_err = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder (SIZE=7): arithmetic reference model plus directed scenarios.
module tb_johnson_decoder;

`ifdef JOHNSON_DECODER_SEQ_CHECK_EN
  localparam int unsigned SEQ = 1;
`else
  localparam int unsigned SEQ = 0;
`endif

  logic       clk;
  logic       r;
  logic [0:7] jc;
  logic       en;
  logic       clr_cnt;
  logic [3:0] phase;
  logic       valid;
  logic       illegal;
  logic       skip_err;
  logic       locked;
  logic [7:0] err_cnt;

  johnson_decoder #(
    .SIZE(7),
    .PW  (4)
  ) dut (
    .clk     (clk),
    .r       (r),
    .jc      (jc),
    .en      (en),
    .clr_cnt (clr_cnt),
    .phase   (phase),
    .valid   (valid),
    .illegal (illegal),
    .skip_err(skip_err),
    .locked  (locked),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Word as an 8-bit number (bit 0 is MSB) with n ones is legal only as the
  // run 1..10..0 (phase n) or 0..01..1 (phase 16-n).
  function automatic int model_phase(input logic [0:7] w, output bit legal);
    int v;
    int n;
    v     = int'(w);
    n     = $countones(w);
    legal = 1'b1;
    if (v == 256 - (1 << (8 - n))) return n;
    if (v == (1 << n) - 1) return 16 - n;
    legal = 1'b0;
    return 0;
  endfunction

  int m_phase;
  int m_err;
  bit m_valid, m_illegal, m_skip, m_locked, m_has_prev;
  bit m_legal, m_succ;
  int m_ph;

  always @(posedge clk or posedge r) begin
    if (r) begin
      m_phase = 0; m_err = 0; m_valid = 0; m_illegal = 0; m_skip = 0;
      m_locked = 0; m_has_prev = 0;
    end else begin
      m_valid = 0; m_illegal = 0; m_skip = 0;
      if (en) begin
        m_ph = model_phase(jc, m_legal);
        if (m_legal) begin
          m_succ  = m_has_prev && (m_ph == (m_phase + 1) % 16);
          m_valid = 1;
`ifdef JOHNSON_DECODER_SEQ_CHECK_EN
          if (m_locked && !m_succ) m_skip = 1;
          m_locked = m_succ;
`endif
          m_has_prev = 1;
          m_phase    = m_ph;
        end else begin
          m_illegal  = 1;
          m_locked   = 0;
          m_has_prev = 0;
        end
      end
      if (clr_cnt) m_err = 0;
      else if ((m_illegal || m_skip) && m_err < 255) m_err = m_err + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("phase",    phase,    m_phase);
      check("valid",    valid,    m_valid);
      check("illegal",  illegal,  m_illegal);
      check("skip_err", skip_err, m_skip);
      check("locked",   locked,   m_locked);
      check("err_cnt",  err_cnt,  m_err);
      check("excl",     illegal & skip_err, 0);
    end
  end

  task automatic step(input logic [0:7] w, input logic e, input logic c);
    jc = w; en = e; clr_cnt = c;
    @(negedge clk);
  endtask

  initial begin
    r = 1'b1; jc = '0; en = 1'b0; clr_cnt = 1'b0;
    @(negedge clk);
    check("rst_phase", phase, 0);
    check("rst_valid", valid, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err_cnt, 0);
    r = 1'b0;
    chk_on = 1'b1;

    // Reset then lock
    step(8'b00000000, 1, 0);
    check("s1_valid", valid, 1); check("s1_phase", phase, 0); check("s1_locked", locked, 0);
    step(8'b10000000, 1, 0);
    check("s2_phase", phase, 1); check("s2_locked", locked, SEQ);
    step(8'b11000000, 1, 0);
    check("s3_phase", phase, 2); check("s3_locked", locked, SEQ);
    step(8'b11100000, 1, 0);
    check("s4_phase", phase, 3);

    // Illegal word while locked at 3
    step(8'b10100000, 1, 0);
    check("ill_flag", illegal, 1); check("ill_valid", valid, 0);
    check("ill_phase", phase, 3); check("ill_locked", locked, 0); check("ill_err", err_cnt, 1);

    // Relock at 2, then skip to 4
    step(8'b10000000, 1, 0);
    check("rl_locked", locked, 0);
    step(8'b11000000, 1, 0);
    step(8'b11110000, 1, 0);
    check("skip_flag", skip_err, SEQ); check("skip_valid", valid, 1);
    check("skip_phase", phase, 4); check("skip_locked", locked, 0); check("skip_err", err_cnt, 1 + SEQ);
    step(8'b11111000, 1, 0);
    check("relock", locked, SEQ); check("p5", phase, 5);

    // Run up through 8 and 9, jump to 13, then wrap 14, 15, 0
    step(8'b11111100, 1, 0);
    step(8'b11111110, 1, 0);
    step(8'b11111111, 1, 0);
    check("p8", phase, 8);
    step(8'b01111111, 1, 0);
    check("p9", phase, 9);
    step(8'b00000111, 1, 0);
    check("p13", phase, 13); check("p13_err", err_cnt, 1 + 2 * SEQ);
    step(8'b00000011, 1, 0);
    check("p14", phase, 14);
    step(8'b00000001, 1, 0);
    check("p15", phase, 15); check("p15_locked", locked, SEQ); check("p15_skip", skip_err, 0);
    step(8'b00000000, 1, 0);
    check("wrap0", phase, 0); check("wrap_locked", locked, SEQ); check("wrap_skip", skip_err, 0);

    // en=0 holds state and emits no pulses
    step(8'b10100000, 0, 0);
    check("hold_ill", illegal, 0); check("hold_valid", valid, 0); check("hold_phase", phase, 0);
    check("hold_locked", locked, SEQ);

    // Lock at 6 then reset mid-lock
    for (int i = 1; i <= 6; i++) begin
      logic [0:7] w;
      w = '0;
      for (int b = 0; b < i; b++) w[b] = 1'b1;
      step(w, 1, 0);
    end
    check("p6", phase, 6); check("p6_locked", locked, SEQ);
    #2 r = 1'b1;
    #1;
    check("arst_phase", phase, 0); check("arst_valid", valid, 0); check("arst_locked", locked, 0);
    check("arst_err", err_cnt, 0); check("arst_ill", illegal, 0); check("arst_skip", skip_err, 0);
    @(negedge clk);
    r = 1'b0;
    step(8'b11111110, 1, 0);
    check("post_valid", valid, 1); check("post_phase", phase, 7); check("post_locked", locked, 0);

    // Saturation and clear
    for (int i = 0; i < 300; i++) step(8'b10100000, 1, 0);
    check("sat", err_cnt, 255);
    step(8'b10100000, 1, 1);
    check("clr", err_cnt, 0); check("clr_ill", illegal, 1);
    step(8'b00000000, 0, 0);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter SIZE, default 7: input code occupies bits [0:SIZE], so the code is SIZE+1 bits wide and has 2*(SIZE+1) legal states.
REQ-002 Parameter PW, default 4: width of the phase output; it SHALL equal clog2(2*(SIZE+1)).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 r  input  1  reset, asynchronous, active-high.
REQ-005 jc  input  [0:SIZE]  Johnson code word under decode; bit 0 is the first bit to set after all-zero.
REQ-006 en  input  1  sample strobe; jc is evaluated only in cycles where en=1.
REQ-007 clr_cnt  input  1  synchronous clear of err_cnt.
REQ-008 phase  output  PW  decoded phase index of the last legal sample.
REQ-009 valid  output  1  pulses 1 cycle when a legal sample has been decoded.
REQ-010 illegal  output  1  pulses 1 cycle when a sampled word is not a legal Johnson state.
REQ-011 skip_err  output  1  pulses 1 cycle when a legal sample breaks sequence while locked.
REQ-012 locked  output  1  level; 1 while the sequence tracker is in LOCKED.
REQ-013 err_cnt  output  8  saturating count of illegal plus skip_err events.

Function
REQ-014 Legal states and phase: for p in 0..SIZE+1, bits [0..p-1]=1 and the rest are 0; for p in SIZE+2..2*SIZE+1, bits [0..p-SIZE-2]=0 and the rest are 1. For SIZE=7: 00000000=0, 10000000=1, 11111111=8, 01111111=9, 00000001=15.
REQ-015 Any other word SHALL be illegal.
REQ-016 Latency: valid, illegal, skip_err, phase and locked SHALL be registered, updating 1 cycle after the en=1 sample edge.
REQ-017 With en=0: no pulses are asserted, and phase, locked and err_cnt hold their values.
REQ-018 On an illegal sample: illegal=1, valid=0, phase is held, and the tracker goes to UNLOCKED.
REQ-019 Successor rule: the successor of phase p is (p+1) mod 2*(SIZE+1); for SIZE=7, 15 wraps to 0.
REQ-020 Tracker state UNLOCKED: a legal sample whose phase is the successor of the previous legal sample's phase, with no intervening illegal sample, moves the tracker to LOCKED. Otherwise it stays UNLOCKED.
REQ-021 Tracker state LOCKED: a legal sample equal to the successor stays LOCKED. Any other legal phase, including a repeat, gives skip_err=1 and valid=1, updates phase, and moves the tracker to UNLOCKED.
REQ-022 The first legal sample after reset only establishes the previous phase; it never locks.
REQ-023 err_cnt increments by 1 on each illegal or skip_err event and saturates at 255.
REQ-024 clr_cnt=1 forces err_cnt to 0 on the next edge; clr_cnt has priority over a simultaneous event.
REQ-025 illegal and skip_err SHALL never be asserted in the same cycle.

Reset
REQ-026 While r=1, all outputs SHALL be forced to 0 asynchronously: phase=0, valid=0, illegal=0, skip_err=0, locked=0, err_cnt=0.
REQ-027 While r=1, the tracker is UNLOCKED and has no previous phase.
REQ-028 Reset asserted mid-sequence SHALL discard the lock and the previous phase.
REQ-029 After r deasserts, the first en sample is treated as the first sample after reset.

Configuration
REQ-030 Macro JOHNSON_DECODER_SEQ_CHECK_EN defined: the sequence tracker, locked, skip_err and the skip contribution to err_cnt are present as specified.
REQ-031 Macro JOHNSON_DECODER_SEQ_CHECK_EN undefined: locked and skip_err are tied to 0, err_cnt counts illegal events only, and no tracker state is built.

Verification
REQ-032 Scenario reset then lock (SIZE=7): after reset, drive en=1 with 00000000, 10000000, 11000000 -> valid each cycle; phase=0,1,2; locked=1 one cycle after the 10000000 sample.
REQ-033 Scenario wrap: locked, drive 00000011 (phase 14), 00000001 (15), 00000000 (0) -> phase 14, 15, 0; locked stays 1; skip_err=0.
REQ-034 Scenario illegal word: locked at phase 3, drive 10100000 -> illegal=1, locked=0, phase stays 3, err_cnt=1.
REQ-035 Scenario skip: locked at phase 2, drive 11110000 (4) -> skip_err=1, valid=1, phase=4, locked=0, err_cnt+1; then 11111000 (5) -> locked=1.
REQ-036 Scenario saturation and clear: 300 illegal samples -> err_cnt=255; then clr_cnt=1 in the same cycle as an illegal sample -> err_cnt=0.
REQ-037 Scenario reset mid-lock: r pulsed while locked at phase 6 -> all outputs 0 immediately; the next sample 11111110 gives valid=1, phase=7, locked=0.
